// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC, PC-source selection and IF/ID register.
// Also captures the immediate byte of two-byte instructions.
module fetch_stage #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = 8'h00,
  parameter logic [ADDR_W-1:0] INT_VEC_ADDR = 8'h01,
  parameter logic [DATA_W-1:0] NOP_INSTR = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write_en,
  input  logic              if_id_write_en,
  input  logic              inject_bubble,
  input  logic              inject_int,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              ret_taken,
  input  logic [ADDR_W-1:0] ret_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [DATA_W-1:0] if_id_imm,
  output logic [ADDR_W-1:0] if_id_pc_next,
  output logic              if_id_valid,
  output logic [3:0]        opcode,
  output logic [1:0]        ra,
  output logic [ADDR_W-1:0] int_ret_pc
);

  typedef enum logic [1:0] {
    S_RSTVEC,
    S_RUN,
    S_INTVEC
  } state_t;

  state_t state;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc + ADDR_W'(1);
  assign opcode = if_id_instr[7:4];
  assign ra     = if_id_instr[3:2];

  // Vector fetches read a fixed address; normal fetch reads at pc.
  always_comb begin
    imem_addr = pc;
    unique case (state)
      S_RSTVEC: imem_addr = RESET_VEC_ADDR;
      S_INTVEC: imem_addr = INT_VEC_ADDR;
      default:  imem_addr = pc;
    endcase
  end

  // PC sequencing and IF/ID register; redirects take priority in order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_RSTVEC;
      pc            <= '0;
      if_id_instr   <= NOP_INSTR;
      if_id_imm     <= '0;
      if_id_pc_next <= '0;
      if_id_valid   <= 1'b0;
      int_ret_pc    <= '0;
    end else begin
      unique case (state)
        S_RSTVEC, S_INTVEC: begin
          pc          <= imem_data;
          if_id_instr <= NOP_INSTR;
          if_id_valid <= 1'b0;
          state       <= S_RUN;
        end
        default: begin
          if (ret_taken) begin
            pc          <= ret_pc;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end else if (branch_taken) begin
            pc          <= branch_target;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end else if (inject_int) begin
            int_ret_pc  <= pc;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            state       <= S_INTVEC;
          end else begin
            if (pc_write_en)
              pc <= pc_inc;
            if (pc_write_en && !if_id_write_en) begin
              if_id_imm <= imem_data;
            end else if (if_id_write_en) begin
              if (inject_bubble) begin
                if_id_instr <= NOP_INSTR;
                if_id_valid <= 1'b0;
              end else begin
                if_id_instr   <= imem_data;
                if_id_pc_next <= pc_inc;
                if_id_valid   <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage.
// Memory model is a 256-byte array read combinationally.
module tb_fetch_stage;

  logic       clk;
  logic       rst;
  logic       pc_write_en;
  logic       if_id_write_en;
  logic       inject_bubble;
  logic       inject_int;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic       ret_taken;
  logic [7:0] ret_pc;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] pc;
  logic [7:0] if_id_instr;
  logic [7:0] if_id_imm;
  logic [7:0] if_id_pc_next;
  logic       if_id_valid;
  logic [3:0] opcode;
  logic [1:0] ra;
  logic [7:0] int_ret_pc;

  logic [7:0] mem [256];
  int errors;
  int checks;

  assign imem_data = mem[imem_addr];

  fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .pc_write_en(pc_write_en),
    .if_id_write_en(if_id_write_en),
    .inject_bubble(inject_bubble),
    .inject_int(inject_int),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .ret_taken(ret_taken),
    .ret_pc(ret_pc),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .pc(pc),
    .if_id_instr(if_id_instr),
    .if_id_imm(if_id_imm),
    .if_id_pc_next(if_id_pc_next),
    .if_id_valid(if_id_valid),
    .opcode(opcode),
    .ra(ra),
    .int_ret_pc(int_ret_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [7:0] t);
    branch_taken = 1'b1;
    branch_target = t;
    step();
    branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    mem[8'h00] = 8'h10;
    mem[8'h10] = 8'h21;
    mem[8'h11] = 8'h00;
    rst = 1'b0;
    #12;
    checks++;
    if (pc !== 8'h00) begin
      errors++;
      $display("FAIL rst_pc got=%h exp=00", pc);
    end
    checks++;
    if (if_id_valid !== 1'b0 || if_id_instr !== 8'h00) begin
      errors++;
      $display("FAIL rst_ifid got=%b/%h exp=0/00",
               if_id_valid, if_id_instr);
    end
    checks++;
    if (imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL rst_addr got=%h exp=00", imem_addr);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if (pc !== 8'h10 || if_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstvec got=%h/%b exp=10/0", pc, if_id_valid);
    end
    step();
    checks++;
    if (if_id_instr !== 8'h21 || opcode !== 4'h2 || ra !== 2'd0) begin
      errors++;
      $display("FAIL first_instr got=%h/%h/%h exp=21/2/0",
               if_id_instr, opcode, ra);
    end
    checks++;
    if (if_id_pc_next !== 8'h11 || if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_pcn got=%h/%b exp=11/1",
               if_id_pc_next, if_id_valid);
    end
  endtask

  task automatic test_imm_fetch();
    mem[8'h20] = 8'hC4;
    mem[8'h21] = 8'h5A;
    redirect(8'h20);
    step();
    checks++;
    if (if_id_instr !== 8'hC4 || pc !== 8'h21) begin
      errors++;
      $display("FAIL ldm_latch got=%h/%h exp=C4/21", if_id_instr, pc);
    end
    if_id_write_en = 1'b0;
    inject_bubble = 1'b1;
    step();
    if_id_write_en = 1'b1;
    inject_bubble = 1'b0;
    checks++;
    if (if_id_imm !== 8'h5A || if_id_instr !== 8'hC4) begin
      errors++;
      $display("FAIL imm got=%h/%h exp=5A/C4", if_id_imm, if_id_instr);
    end
    checks++;
    if (pc !== 8'h22 || if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL imm_pc got=%h/%b exp=22/1", pc, if_id_valid);
    end
  endtask

  task automatic test_redirect_prio();
    ret_taken = 1'b1;
    ret_pc = 8'h40;
    branch_taken = 1'b1;
    branch_target = 8'h80;
    inject_int = 1'b1;
    step();
    ret_taken = 1'b0;
    branch_taken = 1'b0;
    inject_int = 1'b0;
    checks++;
    if (pc !== 8'h40 || imem_addr !== 8'h40) begin
      errors++;
      $display("FAIL prio_pc got=%h/%h exp=40/40", pc, imem_addr);
    end
    checks++;
    if (if_id_instr !== 8'h00 || if_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL prio_ifid got=%h/%b exp=00/0",
               if_id_instr, if_id_valid);
    end
    checks++;
    if (int_ret_pc !== 8'h00 || if_id_imm !== 8'h5A) begin
      errors++;
      $display("FAIL prio_keep got=%h/%h exp=00/5A",
               int_ret_pc, if_id_imm);
    end
  endtask

  task automatic test_interrupt();
    mem[8'h01] = 8'hE0;
    mem[8'hE0] = 8'h31;
    redirect(8'h33);
    inject_int = 1'b1;
    step();
    inject_int = 1'b0;
    checks++;
    if (int_ret_pc !== 8'h33 || imem_addr !== 8'h01) begin
      errors++;
      $display("FAIL int_enter got=%h/%h exp=33/01",
               int_ret_pc, imem_addr);
    end
    checks++;
    if (pc !== 8'h33 || if_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL int_hold got=%h/%b exp=33/0", pc, if_id_valid);
    end
    step();
    checks++;
    if (pc !== 8'hE0 || if_id_valid !== 1'b0 || imem_addr !== 8'hE0) begin
      errors++;
      $display("FAIL int_vec got=%h/%b/%h exp=E0/0/E0",
               pc, if_id_valid, imem_addr);
    end
    step();
    checks++;
    if (if_id_instr !== 8'h31 || if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL isr_first got=%h/%b exp=31/1",
               if_id_instr, if_id_valid);
    end
  endtask

  task automatic test_stall_wrap();
    mem[8'hFE] = 8'hA8;
    mem[8'hFF] = 8'hB4;
    redirect(8'hFE);
    step();
    checks++;
    if (pc !== 8'hFF || if_id_pc_next !== 8'hFF) begin
      errors++;
      $display("FAIL pre_wrap got=%h/%h exp=FF/FF", pc, if_id_pc_next);
    end
    pc_write_en = 1'b0;
    if_id_write_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pc !== 8'hFF || if_id_instr !== 8'hA8 || if_id_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d got=%h/%h/%b exp=FF/A8/1",
                 i, pc, if_id_instr, if_id_valid);
      end
    end
    pc_write_en = 1'b1;
    if_id_write_en = 1'b1;
    step();
    checks++;
    if (pc !== 8'h00 || if_id_pc_next !== 8'h00 || if_id_instr !== 8'hB4) begin
      errors++;
      $display("FAIL wrap got=%h/%h/%h exp=00/00/B4",
               pc, if_id_pc_next, if_id_instr);
    end
  endtask

  task automatic test_async_reset();
    redirect(8'h55);
    inject_int = 1'b1;
    step();
    inject_int = 1'b0;
    checks++;
    if (imem_addr !== 8'h01 || int_ret_pc !== 8'h55) begin
      errors++;
      $display("FAIL ar_pre got=%h/%h exp=01/55", imem_addr, int_ret_pc);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (pc !== 8'h00 || int_ret_pc !== 8'h00 || if_id_imm !== 8'h00) begin
      errors++;
      $display("FAIL ar_state got=%h/%h/%h exp=00/00/00",
               pc, int_ret_pc, if_id_imm);
    end
    checks++;
    if (imem_addr !== 8'h00 || if_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_addr got=%h/%b exp=00/0", imem_addr, if_id_valid);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    pc_write_en = 1'b1;
    if_id_write_en = 1'b1;
    inject_bubble = 1'b0;
    inject_int = 1'b0;
    branch_taken = 1'b0;
    branch_target = 8'h00;
    ret_taken = 1'b0;
    ret_pc = 8'h00;
    test_reset();
    test_imm_fetch();
    test_redirect_prio();
    test_interrupt();
    test_stall_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
